pu_stream: RTL and testbench

PU_STREAM -- requirements
Module: pu_stream

---
 rtl/pu_stream.sv | 163 ++++++++++++++++
 tb/tb_pu_stream.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_stream.sv
// rtl/pu_stream.sv - Three-stage streaming fixed-point neuron: lane MACs, packet accumulate with saturation, activation.
module pu_stream #(
    parameter int NUM_IN    = 4,
    parameter int WIDTH     = 32,
    parameter int FRAC      = 16,
    parameter int ACC_GUARD = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] a,
    input  logic [NUM_IN*WIDTH-1:0] w,
    input  logic                    in_last,
    input  logic [1:0]              act_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out,
    output logic                    ovf
);
    localparam int AW = WIDTH + ACC_GUARD;

    localparam logic signed [AW:0]      ACC_MAX  = {2'b00, {(AW-1){1'b1}}};
    localparam logic signed [AW:0]      ACC_MIN  = {2'b11, {(AW-1){1'b0}}};
    localparam logic signed [AW:0]      RES_MAX  = {{(AW-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW:0]      RES_MIN  = {{(AW-WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic [AW-1:0]           ACC_TOP  = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0]           ACC_BOT  = {1'b1, {(AW-1){1'b0}}};
    localparam logic [WIDTH-1:0]        RES_TOP  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]        RES_BOT  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]        STEP_ONE = WIDTH'(1) << FRAC;

    // Full-precision product, rescaled and truncated to accumulator width.
    function automatic logic [AW-1:0] lane_prod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic signed [2*WIDTH-1:0] m;
        m = {{WIDTH{x[WIDTH-1]}}, x} * {{WIDTH{y[WIDTH-1]}}, y};
        m = m >>> FRAC;
        return m[AW-1:0];
    endfunction

    logic                  s1_valid, s1_last;
    logic [1:0]            s1_mode;
    logic [AW-1:0]         s1_prod [NUM_IN];
    logic                  s2_valid, s2_ovf;
    logic [1:0]            s2_mode;
    logic [WIDTH-1:0]      s2_data;
    logic                  s3_valid, s3_ovf;
    logic [WIDTH-1:0]      s3_data;
    logic [AW-1:0]         acc;
    logic                  pkt_ovf;

    logic                  s1_take, s2_take, s3_take;
    logic [AW-1:0]         tree;
    logic signed [AW:0]    acc_sum;
    logic [AW-1:0]         acc_sat;
    logic                  acc_clip;
    logic [WIDTH-1:0]      res_sat;
    logic                  res_clip;
    logic [WIDTH-1:0]      act_val;

    assign s3_take  = !s3_valid || out_ready;
    assign s2_take  = !s2_valid || s3_take;
    assign s1_take  = !s1_valid || s2_take;
    assign in_ready = s1_take && !rst;

    assign out_valid = s3_valid;
    assign out       = s3_data;
    assign ovf       = s3_ovf;

    always_comb begin
        tree = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            tree = tree + s1_prod[i];
        end
        acc_sum = {acc[AW-1], acc} + {tree[AW-1], tree};
    end

    // One extra bit of headroom lets both clamps compare against the true sum.
    always_comb begin
        acc_sat  = acc_sum[AW-1:0];
        acc_clip = 1'b0;
        if (acc_sum > ACC_MAX) begin
            acc_sat  = ACC_TOP;
            acc_clip = 1'b1;
        end else if (acc_sum < ACC_MIN) begin
            acc_sat  = ACC_BOT;
            acc_clip = 1'b1;
        end
        res_sat  = acc_sum[WIDTH-1:0];
        res_clip = 1'b0;
        if (acc_sum > RES_MAX) begin
            res_sat  = RES_TOP;
            res_clip = 1'b1;
        end else if (acc_sum < RES_MIN) begin
            res_sat  = RES_BOT;
            res_clip = 1'b1;
        end
    end

    always_comb begin
        act_val = s2_data;
        case (s2_mode)
            2'b01:   act_val = s2_data[WIDTH-1] ? '0 : s2_data;
            2'b10:   act_val = (!s2_data[WIDTH-1] && (s2_data != '0)) ? STEP_ONE : '0;
            default: act_val = s2_data;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_mode  <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                s1_prod[i] <= '0;
            end
            s2_valid <= 1'b0;
            s2_ovf   <= 1'b0;
            s2_mode  <= '0;
            s2_data  <= '0;
            s3_valid <= 1'b0;
            s3_ovf   <= 1'b0;
            s3_data  <= '0;
            acc      <= '0;
            pkt_ovf  <= 1'b0;
        end else begin
            if (s3_take) begin
                s3_valid <= s2_valid;
                if (s2_valid) begin
                    s3_data <= act_val;
                    s3_ovf  <= s2_ovf;
                end
            end
            if (s2_take) begin
                s2_valid <= s1_valid && s1_last;
                if (s1_valid && s1_last) begin
                    s2_data <= res_sat;
                    s2_ovf  <= pkt_ovf || res_clip;
                    s2_mode <= s1_mode;
                end
            end
            if (s1_valid && s2_take) begin
                if (s1_last) begin
                    acc     <= '0;
                    pkt_ovf <= 1'b0;
                end else begin
                    acc     <= acc_sat;
                    pkt_ovf <= pkt_ovf || acc_clip;
                end
            end
            if (s1_take) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_last <= in_last;
                    s1_mode <= act_mode;
                    for (int i = 0; i < NUM_IN; i++) begin
                        s1_prod[i] <= lane_prod(a[i*WIDTH +: WIDTH], w[i*WIDTH +: WIDTH]);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pu_stream.sv
// tb/tb_pu_stream.sv - Directed bench for pu_stream with an arithmetic reference model and output scoreboard.
module tb_pu_stream;
    logic         clk, rst, in_valid, in_ready, in_last, out_valid, out_ready, ovf;
    logic [127:0] a, w;
    logic [1:0]   act_mode;
    logic [31:0]  out;

    int errors = 0;
    int checks = 0;
    int n_out  = 0;
    logic [31:0] last_out;
    logic        last_ovf;

    localparam logic [31:0] ONE  = 32'h0001_0000;
    localparam logic [31:0] MONE = 32'hFFFF_0000;
    localparam longint AMAX = 64'sd549755813887;
    localparam longint AMIN = -64'sd549755813888;

    longint      macc = 0;
    logic        movf = 1'b0;
    logic [32:0] exp_q [$];

    pu_stream #(.NUM_IN(4), .WIDTH(32), .FRAC(16), .ACC_GUARD(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .w(w), .in_last(in_last), .act_mode(act_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] pack4(input logic [31:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic longint wrap_aw(input longint v);
        return (v <<< 24) >>> 24;
    endfunction

    // Reference: exact integer arithmetic per packet, results queued in order.
    task automatic model_beat(input logic [127:0] av, wv, input logic last, input logic [1:0] mode);
        longint tree, p, s, v;
        logic   o;
        tree = 0;
        for (int i = 0; i < 4; i++) begin
            p = longint'($signed(av[i*32 +: 32])) * longint'($signed(wv[i*32 +: 32]));
            p = wrap_aw(p >>> 16);
            tree = wrap_aw(tree + p);
        end
        s = macc + tree;
        if (!last) begin
            if (s > AMAX) begin macc = AMAX; movf = 1'b1; end
            else if (s < AMIN) begin macc = AMIN; movf = 1'b1; end
            else macc = s;
        end else begin
            o = movf;
            v = s;
            if (v > 64'sd2147483647) begin v = 64'sd2147483647; o = 1'b1; end
            else if (v < -64'sd2147483648) begin v = -64'sd2147483648; o = 1'b1; end
            if (mode == 2'b01 && v < 0) v = 0;
            if (mode == 2'b10) v = (v > 0) ? 64'sd65536 : 64'sd0;
            exp_q.push_back({v[31:0], o});
            macc = 0;
            movf = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            macc = 0;
            movf = 1'b0;
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                logic [32:0] e;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got out=%h ovf=%b, no result expected", out, ovf);
                end else begin
                    e = exp_q.pop_front();
                    if (out !== e[32:1] || ovf !== e[0]) begin
                        errors++;
                        $display("FAIL model_output got out=%h ovf=%b, expected out=%h ovf=%b", out, ovf, e[32:1], e[0]);
                    end
                end
                last_out = out;
                last_ovf = ovf;
                n_out++;
            end
            if (in_valid && in_ready) model_beat(a, w, in_last, act_mode);
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send(input logic [127:0] av, wv, input logic last, input logic [1:0] mode);
        logic took;
        int   n;
        a = av; w = wv; in_last = last; act_mode = mode; in_valid = 1'b1;
        took = 1'b0;
        n = 0;
        while (!took && n < 200) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        check("send_accepted", 64'(took), 64'd1);
    endtask

    task automatic wait_out(input int target);
        for (int i = 0; i < 100 && n_out < target; i++) begin
            @(posedge clk);
            #1;
        end
        check("output_arrived", 64'(n_out >= target), 64'd1);
    endtask

    logic [127:0] a_seq, w_ones, w_mones, w_lane0;
    int base;

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; w = '0; in_last = 1'b0; act_mode = 2'b00; out_ready = 1'b1;
        a_seq   = pack4(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000);
        w_ones  = pack4(ONE, ONE, ONE, ONE);
        w_mones = pack4(MONE, MONE, MONE, MONE);
        w_lane0 = pack4(ONE, 32'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out", 64'(out), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", 64'(in_ready), 64'd1);

        // Basic dot product and two-edge latency.
        base = n_out;
        send(a_seq, w_ones, 1'b1, 2'b00);
        @(posedge clk); #1;
        check("latency_t1_not_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check("latency_t2_valid", 64'(out_valid), 64'd1);
        wait_out(base + 1);
        check("dot_identity", 64'(last_out), 64'h000A_0000);
        check("dot_identity_ovf", 64'(last_ovf), 64'd0);

        // Activation variants on negative and positive sums.
        send(a_seq, w_mones, 1'b1, 2'b01);
        wait_out(base + 2);
        check("neg_relu", 64'(last_out), 64'h0);
        send(a_seq, w_mones, 1'b1, 2'b10);
        wait_out(base + 3);
        check("neg_step", 64'(last_out), 64'h0);
        send(a_seq, w_mones, 1'b1, 2'b00);
        wait_out(base + 4);
        check("neg_identity", 64'(last_out), 64'hFFF6_0000);
        send(a_seq, w_ones, 1'b1, 2'b10);
        wait_out(base + 5);
        check("pos_step", 64'(last_out), 64'h0001_0000);
        send(a_seq, w_ones, 1'b1, 2'b11);
        wait_out(base + 6);
        check("mode3_identity", 64'(last_out), 64'h000A_0000);

        // Two-beat packet: no output until the last beat.
        base = n_out;
        send(pack4(ONE, ONE, ONE, ONE), w_ones, 1'b0, 2'b00);
        repeat (4) @(posedge clk);
        #1;
        check("no_output_mid_packet", 64'(n_out), 64'(base));
        send(pack4(ONE, ONE, ONE, ONE), w_ones, 1'b1, 2'b00);
        wait_out(base + 1);
        check("two_beat_sum", 64'(last_out), 64'h0008_0000);

        // Back-pressure: three packets fill the pipe, the rest wait.
        base = n_out;
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) send(pack4(32'(k) << 16, 0, 0, 0), w_lane0, 1'b1, 2'b00);
        check("in_ready_full", 64'(in_ready), 64'd0);
        a = pack4(32'h0004_0000, 0, 0, 0); w = w_lane0; in_last = 1'b1; act_mode = 2'b00; in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("held_in_ready", 64'(in_ready), 64'd0);
        check("held_out_valid", 64'(out_valid), 64'd1);
        check("held_out_value", 64'(out), 64'h0001_0000);
        check("held_no_transfer", 64'(n_out), 64'(base));
        out_ready = 1'b1;
        for (int k = 4; k <= 6; k++) send(pack4(32'(k) << 16, 0, 0, 0), w_lane0, 1'b1, 2'b00);
        wait_out(base + 6);
        check("six_in_order_last", 64'(last_out), 64'h0006_0000);

        // Output saturation, then a clean packet.
        base = n_out;
        send(pack4(32'h7FFF_0000, 0, 0, 0), pack4(32'h0002_0000, 0, 0, 0), 1'b1, 2'b00);
        wait_out(base + 1);
        check("sat_value", 64'(last_out), 64'h7FFF_FFFF);
        check("sat_ovf", 64'(last_ovf), 64'd1);
        send(a_seq, w_ones, 1'b1, 2'b00);
        wait_out(base + 2);
        check("post_sat_ovf_clear", 64'(last_ovf), 64'd0);

        // Accumulator clamps at its own range before the final beat pulls it back.
        base = n_out;
        send(pack4(32'h7FFF_0000, 0, 0, 0), pack4(32'h00FF_0000, 0, 0, 0), 1'b0, 2'b00);
        send(pack4(32'h7FFF_0000, 0, 0, 0), pack4(32'h00FF_0000, 0, 0, 0), 1'b0, 2'b00);
        send(pack4(32'h7FFF_0000, 0, 0, 0), pack4(32'hFF01_0000, 0, 0, 0), 1'b1, 2'b00);
        wait_out(base + 1);
        check("acc_sat_value", 64'(last_out), 64'h7FFF_FFFF);
        check("acc_sat_ovf", 64'(last_ovf), 64'd1);

        // Reset mid-packet with a result held at the output.
        base = n_out;
        out_ready = 1'b0;
        send(pack4(32'h0002_0000, 0, 0, 0), w_lane0, 1'b1, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_out_valid", 64'(out_valid), 64'd1);
        send(pack4(ONE, ONE, ONE, ONE), w_ones, 1'b0, 2'b00);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_out", 64'(out), 64'd0);
        check("async_rst_ovf", 64'(ovf), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_after_pulse", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        send(pack4(ONE, 0, 0, 0), w_lane0, 1'b1, 2'b00);
        wait_out(base + 1);
        check("post_rst_fresh_acc", 64'(last_out), 64'h0001_0000);
        repeat (3) @(posedge clk);
        #1;
        check("no_stale_outputs", 64'(n_out), 64'(base + 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end
endmodule
